// File: rtl/regfile_mp.sv
// Two-write/two-read register file with optional zero register and write forwarding.
// A sequential init engine loads the array after reset, so the array itself needs no reset.
module regfile_mp #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter bit          ZERO_REG  = 1'b1,
  parameter bit          INIT_MODE = 1'b1,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic              ready,
  output logic              wr_conflict,
  output logic              wr_drop
);

  localparam int unsigned     Depth   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LastPtr = (ADDR_W + 1)'(Depth - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W:0]       ptr_q, ptr_d;
  logic                  wr_conflict_q, wr_conflict_d;
  logic                  wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0]     mem_q [Depth];
  logic [DATA_W-1:0]     init_val;
  logic                  run;
  logic                  zero_hit0, zero_hit1;
  logic                  wr0_ok, wr1_ok;
  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;

  always_comb begin
    run       = (state_q == StRun);
    zero_hit0 = ZERO_REG && (wa0 == '0);
    zero_hit1 = ZERO_REG && (wa1 == '0);
    wr0_ok    = run && we0 && !zero_hit0;
    wr1_ok    = run && we1 && !zero_hit1;

    state_d = state_q;
    ptr_d   = ptr_q;
    if (!run) begin
      ptr_d = ptr_q + (ADDR_W + 1)'(1);
      if (ptr_q == LastPtr) state_d = StRun;
    end

    wr_conflict_d = wr0_ok && wr1_ok && (wa0 == wa1);
    // During init every external write is dropped; in run only zero-register writes are.
    wr_drop_d     = run ? ((we0 && zero_hit0) || (we1 && zero_hit1)) : (we0 || we1);

    init_val = '0;
    if (INIT_MODE) begin
      for (int b = 0; b < int'(DATA_W) && b < int'(ADDR_W); b++) init_val[b] = ptr_q[b];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StInit;
      ptr_q         <= '0;
      wr_conflict_q <= 1'b0;
      wr_drop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      wr_conflict_q <= wr_conflict_d;
      wr_drop_q     <= wr_drop_d;
    end
  end

  // Port 1 is written last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[ptr_q[ADDR_W-1:0]] <= init_val;
    end else begin
      if (wr0_ok) mem_q[wa0] <= wd0;
      if (wr1_ok) mem_q[wa1] <= wd1;
    end
  end

  assign rd_addr = {rs2, rs1};

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem_q[rd_addr[p]];
      if (BYPASS && we0 && (wa0 == rd_addr[p])) rd_data[p] = wd0;
      if (BYPASS && we1 && (wa1 == rd_addr[p])) rd_data[p] = wd1;
      if (!run || (ZERO_REG && (rd_addr[p] == '0))) rd_data[p] = '0;
    end
  end

  assign data1       = rd_data[0];
  assign data2       = rd_data[1];
  assign ready       = run;
  assign wr_conflict = wr_conflict_q;
  assign wr_drop     = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default instance, a no-bypass/no-zero-reg instance sharing
// its stimulus, and a small zero-init instance.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1;
  logic [4:0]  wa0, wa1, rs1, rs2;
  logic [31:0] wd0, wd1;

  logic [31:0] d1_a, d2_a, d1_b, d2_b;
  logic        rdy_a, cf_a, dr_a, rdy_b, cf_b, dr_b;

  logic [2:0]  rs1_s;
  logic [15:0] d1_s, d2_s;
  logic        rdy_s, cf_s, dr_s;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rs1(rs1), .rs2(rs2), .data1(d1_a), .data2(d2_a),
    .ready(rdy_a), .wr_conflict(cf_a), .wr_drop(dr_a)
  );

  regfile_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rs1(rs1), .rs2(rs2), .data1(d1_b), .data2(d2_b),
    .ready(rdy_b), .wr_conflict(cf_b), .wr_drop(dr_b)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .INIT_MODE(1'b0)) u_small (
    .clk(clk), .reset(reset),
    .we0(1'b0), .wa0(3'd0), .wd0(16'h0), .we1(1'b0), .wa1(3'd0), .wd1(16'h0),
    .rs1(rs1_s), .rs2(3'd7), .data1(d1_s), .data2(d2_s),
    .ready(rdy_s), .wr_conflict(cf_s), .wr_drop(dr_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  initial begin
    reset = 1'b0;
    clear_writes();
    rs1 = 5'd7; rs2 = 5'd31; rs1_s = 3'd0;
    #2;
    check_eq("rst_ready", {31'b0, rdy_a}, 32'd0);
    check_eq("rst_conflict", {31'b0, cf_a}, 32'd0);
    check_eq("rst_drop", {31'b0, dr_a}, 32'd0);
    check_eq("rst_data1", d1_a, 32'd0);
    check_eq("rst_data2", d2_a, 32'd0);

    step();
    reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 3) begin
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h5555_5555;
      end
      if (i == 4) begin
        check_eq("init_drop_hi", {31'b0, dr_a}, 32'd1);
        check_eq("init_read0", d1_a, 32'd0);
        clear_writes();
      end
      if (i == 5) check_eq("init_drop_lo", {31'b0, dr_a}, 32'd0);
      if (i == 7) check_eq("small_ready_7", {31'b0, rdy_s}, 32'd0);
      if (i == 8) check_eq("small_ready_8", {31'b0, rdy_s}, 32'd1);
      if (i == 31) check_eq("ready_31", {31'b0, rdy_a}, 32'd0);
      if (i == 32) begin
        check_eq("ready_32", {31'b0, rdy_a}, 32'd1);
        check_eq("ready_32_nb", {31'b0, rdy_b}, 32'd1);
      end
    end

    #1;
    check_eq("init_rs1_7", d1_a, 32'd7);
    check_eq("init_rs2_31", d2_a, 32'd31);
    rs1 = 5'd0; #1;
    check_eq("init_rs1_0", d1_a, 32'd0);
    check_eq("init_rs1_0_nb", d1_b, 32'd0);
    rs1 = 5'd3; #1;
    check_eq("init_wr_ignored", d1_a, 32'd3);
    for (int a = 0; a < 8; a++) begin
      rs1_s = 3'(a); #1;
      check_eq($sformatf("small_zero_%0d", a), {16'h0, d1_s}, 32'd0);
    end

    // Forwarding vs pre-edge contents.
    rs1 = 5'd5; we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; #1;
    check_eq("byp_same_cycle", d1_a, 32'hDEAD_BEEF);
    check_eq("nobyp_pre_edge", d1_b, 32'd5);
    step(); clear_writes(); #1;
    check_eq("byp_after", d1_a, 32'hDEAD_BEEF);
    check_eq("nobyp_after", d1_b, 32'hDEAD_BEEF);

    // Same-address double write: port 1 wins.
    rs2 = 5'd9;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1111;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h2222; #1;
    check_eq("byp_prio", d2_a, 32'h2222);
    check_eq("conflict_pre", {31'b0, cf_a}, 32'd0);
    step(); clear_writes(); #1;
    check_eq("conflict_hi", {31'b0, cf_a}, 32'd1);
    check_eq("conflict_hi_nb", {31'b0, cf_b}, 32'd1);
    check_eq("conflict_data", d2_a, 32'h2222);
    check_eq("conflict_data_nb", d2_b, 32'h2222);
    step();
    check_eq("conflict_lo", {31'b0, cf_a}, 32'd0);

    // Zero register write.
    rs1 = 5'd0; we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; #1;
    check_eq("zero_byp_blocked", d1_a, 32'd0);
    check_eq("zero_nb_pre", d1_b, 32'd0);
    step(); clear_writes(); #1;
    check_eq("zero_drop_hi", {31'b0, dr_a}, 32'd1);
    check_eq("zero_drop_nb", {31'b0, dr_b}, 32'd0);
    check_eq("zero_stays", d1_a, 32'd0);
    check_eq("zero_nb_stored", d1_b, 32'hFFFF_FFFF);
    step();
    check_eq("zero_drop_lo", {31'b0, dr_a}, 32'd0);

    // Mid-run reset restarts initialisation.
    rs1 = 5'd12; we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h0000_ABCD;
    step(); clear_writes(); #1;
    check_eq("pre_rst_data", d1_a, 32'h0000_ABCD);
    #2;
    reset = 1'b0; #1;
    check_eq("midrst_ready", {31'b0, rdy_a}, 32'd0);
    check_eq("midrst_read", d1_a, 32'd0);
    step();
    reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 10) check_eq("reinit_read", d1_a, 32'd0);
      if (i == 31) check_eq("reinit_ready_31", {31'b0, rdy_a}, 32'd0);
    end
    check_eq("reinit_ready_32", {31'b0, rdy_a}, 32'd1);
    check_eq("reinit_e12", d1_a, 32'd12);
    check_eq("reinit_e12_nb", d1_b, 32'd12);
    check_eq("reinit_small_ready", {31'b0, rdy_s}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
